// File: rtl/load_align_unit_if.sv
// Load-unit bus bundle: request, memory-read and response channels.
// Handshakes: a transfer happens on a cycle where valid and ready are both high; valid is held with payload stable until then.
interface load_align_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_data;
  logic              rsp_fault;

  modport master (
    output req_valid, req_funct3, req_addr, mem_rvalid, mem_rdata, rsp_ready,
    input  req_ready, mem_req_valid, mem_addr, rsp_valid, rsp_data, rsp_fault
  );

  modport slave (
    input  req_valid, req_funct3, req_addr, mem_rvalid, mem_rdata, rsp_ready,
    output req_ready, mem_req_valid, mem_addr, rsp_valid, rsp_data, rsp_fault
  );
endinterface

// File: rtl/load_align_unit.sv
// Sequential load-data unit: one or two aligned reads, byte/half/word/dword extraction and extension.
// Optional LOAD_MISALIGN_SPLIT_EN: split word-crossing loads into two beats instead of faulting them.
module load_align_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  load_align_unit_if.slave  bus,
  output logic [1:0]        dbg_state
);
  localparam int BYTES = XLEN / 8;
  localparam int OW    = $clog2(BYTES);

`ifdef LOAD_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t          state;
  logic [2:0]      funct3_q;
  logic [OW-1:0]   off_q;
  logic            cross_q;
  logic [XLEN-1:0] lo_q;

  logic              legal;
  logic [3:0]        size_b;
  logic [4:0]        off_sum;
  logic              cross_req;
  logic [ADDR_W-1:0] aligned_req;
  logic [2*XLEN-1:0] merged;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   ext;

  assign dbg_state = state;

  always_comb begin
    legal = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
      3'b011, 3'b110:                         legal = (XLEN == 64);
      default:                                legal = 1'b0;
    endcase
  end

  // A load crosses when its last byte lies beyond the addressed word.
  assign size_b      = 4'd1 << bus.req_funct3[1:0];
  assign off_sum     = 5'(bus.req_addr[OW-1:0]) + 5'(size_b);
  assign cross_req   = off_sum > 5'(BYTES);
  assign aligned_req = {bus.req_addr[ADDR_W-1:OW], {OW{1'b0}}};

  always_comb begin
    merged  = (state == RD1) ? {bus.mem_rdata, lo_q} : {{XLEN{1'b0}}, bus.mem_rdata};
    shifted = XLEN'(merged >> {off_q, 3'b000});
    case (funct3_q)
      3'b000:  ext = XLEN'($signed(shifted[7:0]));
      3'b001:  ext = XLEN'($signed(shifted[15:0]));
      3'b010:  ext = XLEN'($signed(shifted[31:0]));
      3'b011:  ext = shifted;
      3'b100:  ext = XLEN'(shifted[7:0]);
      3'b101:  ext = XLEN'(shifted[15:0]);
      3'b110:  ext = XLEN'(shifted[31:0]);
      default: ext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      bus.req_ready     <= 1'b1;
      bus.mem_req_valid <= 1'b0;
      bus.mem_addr      <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_data      <= '0;
      bus.rsp_fault     <= 1'b0;
      funct3_q          <= '0;
      off_q             <= '0;
      cross_q           <= 1'b0;
      lo_q              <= '0;
    end else begin
      bus.mem_req_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            funct3_q      <= bus.req_funct3;
            off_q         <= bus.req_addr[OW-1:0];
            cross_q       <= cross_req;
            if (!legal || (cross_req && !SPLIT)) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_fault <= 1'b1;
              bus.rsp_data  <= '0;
            end else begin
              state             <= RD0;
              bus.mem_req_valid <= 1'b1;
              bus.mem_addr      <= aligned_req;
            end
          end
        end
        RD0: begin
          if (bus.mem_rvalid) begin
            lo_q <= bus.mem_rdata;
            if (cross_q) begin
              state             <= RD1;
              bus.mem_req_valid <= 1'b1;
              bus.mem_addr      <= bus.mem_addr + ADDR_W'(BYTES);
            end else begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_fault <= 1'b0;
              bus.rsp_data  <= ext;
            end
          end
        end
        RD1: begin
          if (bus.mem_rvalid) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_fault <= 1'b0;
            bus.rsp_data  <= ext;
          end
        end
        RESP: begin
          // Returning to IDLE re-opens req_ready only from the following cycle.
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit (XLEN=32): directed cases, then random loads against a byte-level memory model.
module tb_load_align_unit;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;

`ifdef LOAD_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  load_align_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  load_align_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] beats_q [$];
  int          lat_sum   = 0;
  int          lat_force = 0;

  function automatic logic [31:0] get_word(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = get_word({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  // Reference: assemble the load byte by byte from memory, then extend.
  function automatic void model(input logic [2:0] f3, input logic [31:0] a,
                                output logic [31:0] d, output logic f, output int nb);
    int sz;
    int off;
    logic [63:0] v;
    d  = '0;
    f  = 1'b1;
    nb = 0;
    if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return;
    sz  = 1 << f3[1:0];
    off = int'(a[1:0]);
    if ((off + sz > 4) && !SPLIT) return;
    v = '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = byte_at(a + 32'(i));
    if (!f3[2] && v[8*sz-1]) for (int i = 8*sz; i < 64; i++) v[i] = 1'b1;
    d  = v[31:0];
    f  = 1'b0;
    nb = (off + sz > 4) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // memory responder: one read per pulse, reply after 1..3 cycles (or lat_force)
  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      if (bus.mem_req_valid === 1'b1) begin
        int          l;
        logic [31:0] a;
        a = bus.mem_addr;
        beats_q.push_back(a);
        l = (lat_force != 0) ? lat_force : int'($urandom_range(1, 3));
        lat_sum += l;
        repeat (l) @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = get_word(a);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
      end else begin
        @(negedge clk);
      end
    end
  end

  // driver: called at a negedge with the unit idle
  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input int hold);
    logic [31:0] ed;
    logic        ef;
    int          enb;
    int          cyc;
    logic [31:0] a0;
    model(f3, a, ed, ef, enb);
    a0 = {a[31:2], 2'b00};
    beats_q.delete();
    lat_sum = 0;
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    @(negedge clk);
    bus.req_valid = 1'b0;
    cyc = 0;
    while (bus.rsp_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("rsp_timeout", 64'(cyc < 40), 64'd1);
    if (cyc >= 40) return;
    chk("latency", 64'(cyc), 64'(enb + lat_sum));
    chk("rsp_data", 64'(bus.rsp_data), 64'(ed));
    chk("rsp_fault", 64'(bus.rsp_fault), 64'(ef));
    chk("beat_count", 64'(beats_q.size()), 64'(enb));
    if (enb > 0 && beats_q.size() > 0) chk("beat0_addr", 64'(beats_q[0]), 64'(a0));
    if (enb > 1 && beats_q.size() > 1) chk("beat1_addr", 64'(beats_q[1]), 64'(a0 + 32'd4));
    for (int i = 0; i < hold; i++) begin
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_rsp_data", 64'(bus.rsp_data), 64'(ed));
      chk("hold_rsp_fault", 64'(bus.rsp_fault), 64'(ef));
      chk("hold_no_beat", 64'(bus.mem_req_valid), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_dropped", 64'(bus.rsp_valid), 64'd0);
    chk("req_ready_back", 64'(bus.req_ready), 64'd1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    chk({tag, "_mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'd0);
    chk({tag, "_rsp_fault"}, 64'(bus.rsp_fault), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=time_limit expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.rsp_ready  = 1'b0;
    rst            = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    mem[32'h100] = 32'h80FF_1234;
    mem[32'h200] = 32'hAABB_CCDD;
    mem[32'h204] = 32'h1122_3344;
    mem[32'h400] = 32'h8001_0000;
    mem[32'h0]   = 32'h5566_7788;

    do_load(3'b000, 32'h103, 5);          // lb, sign bit set, held response
    do_load(3'b101, 32'h402, 0);          // lhu
    do_load(3'b001, 32'h402, 1);          // lh
    do_load(3'b001, 32'h401, 0);          // lh misaligned, not crossing
    do_load(3'b010, 32'h203, 2);          // lw crossing: split or fault
    do_load(3'b011, 32'h008, 0);          // ld illegal at XLEN=32
    do_load(3'b111, 32'h100, 0);          // reserved funct3
    do_load(3'b110, 32'h100, 0);          // lwu illegal at XLEN=32
    do_load(3'b010, 32'hFFFF_FFFE, 0);    // crossing at top of address space
    do_load(3'b100, 32'hFFFF_FFFF, 0);    // lbu never crosses
    do_load(3'b010, 32'h200, 0);          // aligned lw

    // reset during RD0 with a late read reply
    lat_force      = 4;
    bus.req_valid  = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h300;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat_force     = 0;
    chk("rd0_pulse", 64'(bus.mem_req_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_values("midreset");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("late_rvalid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("late_rvalid_state", 64'(dbg_state), 64'd0);
    end
    do_load(3'b000, 32'h103, 0);

    for (int n = 0; n < 80; n++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 1) == 0) ? $urandom : 32'h1000 + 32'($urandom_range(0, 63));
      do_load(f3, a, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
